dino_game_core: RTL and testbench
=================================

// Module: dino_game_core
// PURPOSE
//  Parametrised successor to the single-obstacle game controller: runner game core with N obstacle slots,
//  LFSR-driven spawning, signed jump physics, saturating score and high score. Sits between vga_controller
//  (hCount/vCount/bright) and the top, feeding rgb to the VGA pins and score to the 7-segment driver.
// PARAMETERS
//  NUM_OBST    4      obstacle slots (1..8)
//  SCORE_W     16     score / hi_score width
//  GROUND_Y    515    ground line row; dino bottom rests here
//  DINO_X      200    dino left column
//  DINO_SIZE   50     dino square side (px)
//  OBST_W      20     obstacle width (px)
//  OBST_H      40     obstacle height (px)
//  SPAWN_X     780    spawn column of new obstacle
//  OBST_SPEED  4      px per tick leftward
//  JUMP_V      12     initial upward speed (px/tick)
//  GRAVITY     1      speed change per tick
//  MIN_GAP     40     min ticks between spawns
//  MAX_GAP     120    forced spawn after this many ticks
//  LFSR_SEED   16'hACE1  nonzero LFSR reset value
// PORTS
//  clk       in   1        system clock
//  rst       in   1        synchronous reset, active-low
//  tick      in   1        one-clk move enable (frame rate); all motion advances only on tick
//  up        in   1        jump / start / restart button (debounced level)
//  bright    in   1        display-active from vga_controller
//  hCount    in   10       pixel column
//  vCount    in   10       pixel row
//  rgb       out  12       pixel colour, 1-clk latency from hCount/vCount
//  score     out  SCORE_W  current score
//  hi_score  out  SCORE_W  best score since reset
//  state     out  2        INI=0, GAME=1, DONE=2
//  collide   out  1        registered collision flag
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=INI, score=0, hi_score=0, rgb=0, collide=0, ypos=GROUND_Y, vel=0,
//   all slots inactive, gap counter=0, LFSR=LFSR_SEED, up_d=0. Reset mid-GAME aborts immediately.
//  up_rise = up & ~up_d (up_d registered every clk). LFSR 16-bit Fibonacci (taps 16,14,13,11), steps every clk.
//  FSM: INI -up_rise-> GAME (score cleared on entry); GAME -collide-> DONE; DONE -up_rise-> INI.
//   On GAME->DONE: hi_score <= max(hi_score, score). States 3 unreachable -> INI next clk.
//  Physics (GAME, tick): if ypos==GROUND_Y && up: vel=-JUMP_V. Then ypos+=vel, vel+=GRAVITY (signed 11b).
//   If new ypos>=GROUND_Y: ypos=GROUND_Y, vel=0. up while airborne ignored. No motion outside GAME.
//  Obstacles (GAME, tick): active x -= OBST_SPEED; slot with x < OBST_SPEED retires (inactive, no wrap) and
//   adds 1 to score, saturating at 2^SCORE_W-1; multiple retirements same tick add count.
//  Spawn (GAME, tick): gap++ (saturate); if (gap>=MIN_GAP && LFSR[1:0]==0) || gap>=MAX_GAP, lowest free
//   slot gets x=SPAWN_X, gap=0. No free slot: spawn skipped, gap held. Slots cleared on INI->GAME.
//  Collision: combinational overlap of dino box [DINO_X,+DINO_SIZE) x [ypos-DINO_SIZE,ypos) with any active
//   box [x,+OBST_W) x [GROUND_Y-OBST_H,GROUND_Y); registered into collide every clk in GAME, 0 elsewhere.
//   State goes DONE on clk after collide=1; motion frozen from that clk. Collision wins over retirement in
//   same tick: no score increment for that tick.
//  Render (registered): bright=0 -> 0; else priority dino 12'h0F0 (12'hF00 in DONE) > obstacle 12'hF00 >
//   ground row vCount==GROUND_Y 12'h888 > background 12'hFFF. Obstacles drawn in GAME and DONE only.
// TESTING
//  1 rst=0 2 clks, then 1 -> state=0, score=0, hi_score=0, rgb=0, collide=0; no up for 1000 clks -> state stays 0.
//  2 INI, up held 5 clks -> single GAME entry; ypos sequence per tick 503,492,482,... back to 515, vel=0 after exactly 25 ticks.
//  3 GAME, no jumps -> first obstacle by tick 120, reaches dino, collide=1, state=2 next clk, hi_score=score.
//  4 SCORE_W=4, jump timed over 17 obstacles -> score 1..15 then holds 15.
//  5 NUM_OBST=1, MIN_GAP=1 -> never two active; spawn resumes only after retirement; gap held meanwhile.
//  6 bright=1, hc=210, vc=500 in INI -> rgb=12'h0F0 one clk later; bright=0 -> 0; vc=515, hc=0 -> 12'h888.

Source files
------------

// File: rtl/dino_game_core.sv
// Runner game core: N obstacle slots, LFSR-driven spawning, signed jump physics,
// saturating score / high score and a registered pixel renderer for the VGA path.
module dino_game_core #(
    parameter int          NUM_OBST   = 4,
    parameter int          SCORE_W    = 16,
    parameter int          GROUND_Y   = 515,
    parameter int          DINO_X     = 200,
    parameter int          DINO_SIZE  = 50,
    parameter int          OBST_W     = 20,
    parameter int          OBST_H     = 40,
    parameter int          SPAWN_X    = 780,
    parameter int          OBST_SPEED = 4,
    parameter int          JUMP_V     = 12,
    parameter int          GRAVITY    = 1,
    parameter int          MIN_GAP    = 40,
    parameter int          MAX_GAP    = 120,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               up,
    input  logic               bright,
    input  logic [9:0]         hCount,
    input  logic [9:0]         vCount,
    output logic [11:0]        rgb,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] hi_score,
    output logic [1:0]         state,
    output logic               collide
);
    typedef enum logic [1:0] {
        S_INI  = 2'd0,
        S_GAME = 2'd1,
        S_DONE = 2'd2,
        S_BAD  = 2'd3
    } state_t;

    localparam int GAP_W = $clog2(MAX_GAP + 2);
    localparam int CNT_W = $clog2(NUM_OBST + 1);
    localparam int SUM_W = SCORE_W + CNT_W;

    localparam logic signed [10:0] GY    = 11'(GROUND_Y);
    localparam logic signed [10:0] JV    = 11'(JUMP_V);
    localparam logic signed [10:0] GR    = 11'(GRAVITY);
    localparam logic signed [10:0] DSZ   = 11'(DINO_SIZE);
    localparam logic signed [10:0] OTOP  = 11'(GROUND_Y - OBST_H);
    localparam logic [10:0]        DX_L  = 11'(DINO_X);
    localparam logic [10:0]        DX_R  = 11'(DINO_X + DINO_SIZE);
    localparam logic [10:0]        OW    = 11'(OBST_W);
    localparam logic [9:0]         SPD   = 10'(OBST_SPEED);
    localparam logic [9:0]         SPX   = 10'(SPAWN_X);
    localparam logic [9:0]         GROW  = 10'(GROUND_Y);
    localparam logic [GAP_W-1:0]   G_MIN = GAP_W'(MIN_GAP);
    localparam logic [GAP_W-1:0]   G_MAX = GAP_W'(MAX_GAP);
    localparam logic [SUM_W-1:0]   S_CAP = SUM_W'({SCORE_W{1'b1}});

    state_t                  st_q;
    logic                    up_q;
    logic [15:0]             lfsr_q;
    logic signed [10:0]      ypos_q, ypos_d;
    logic signed [10:0]      vel_q, vel_d;
    logic [NUM_OBST-1:0]     act_q, act_d;
    logic [9:0]              ox_q [NUM_OBST];
    logic [9:0]              ox_d [NUM_OBST];
    logic [GAP_W-1:0]        gap_q, gap_d;
    logic [SCORE_W-1:0]      score_q, score_d, hi_q;
    logic                    collide_q;
    logic [11:0]             rgb_q, rgb_d;

    logic                    up_rise_s, move_s, coll_s, y_hit_s;
    logic                    dino_px_s, obst_px_s, spawn_want_s;
    logic signed [10:0]      vel_t_s, ypos_t_s, vc_s;
    logic [10:0]             hc_s;
    logic [NUM_OBST-1:0]     free_s;
    logic [GAP_W-1:0]        gap_inc_s;
    logic [CNT_W-1:0]        ret_cnt_s;
    logic [SUM_W-1:0]        sum_s;

    assign up_rise_s    = up & ~up_q;
    assign hc_s         = {1'b0, hCount};
    assign vc_s         = $signed({1'b0, vCount});
    assign vel_t_s      = (ypos_q == GY && up) ? -JV : vel_q;
    assign ypos_t_s     = ypos_q + vel_t_s;
    // One-hot of the lowest inactive slot; all-zero when every slot is busy.
    assign free_s       = ~act_q & (act_q + NUM_OBST'(1));
    assign gap_inc_s    = (gap_q == {GAP_W{1'b1}}) ? gap_q : gap_q + GAP_W'(1);
    assign spawn_want_s = ((gap_inc_s >= G_MIN) && (lfsr_q[1:0] == 2'b00)) || (gap_inc_s >= G_MAX);
    assign y_hit_s      = ((ypos_q - DSZ) < GY) && (ypos_q > OTOP);
    assign dino_px_s    = (hc_s >= DX_L) && (hc_s < DX_R) && (vc_s >= ypos_q - DSZ) && (vc_s < ypos_q);
    // A tick that coincides with a fresh collision is swallowed so nothing retires or scores on it.
    assign move_s       = (st_q == S_GAME) && tick && !collide_q && !coll_s;

    // Box overlap tests for collision and obstacle pixels.
    always_comb begin
        coll_s    = 1'b0;
        obst_px_s = 1'b0;
        for (int i = 0; i < NUM_OBST; i++) begin
            if (act_q[i] && y_hit_s && ({1'b0, ox_q[i]} < DX_R) && ({1'b0, ox_q[i]} + OW > DX_L)) begin
                coll_s = 1'b1;
            end else begin
                coll_s = coll_s;
            end
            if (act_q[i] && (hc_s >= {1'b0, ox_q[i]}) && (hc_s < {1'b0, ox_q[i]} + OW) &&
                (vc_s >= OTOP) && (vc_s < GY)) begin
                obst_px_s = 1'b1;
            end else begin
                obst_px_s = obst_px_s;
            end
        end
    end

    // Per-tick motion: jump physics, obstacle scroll/retire/spawn, score.
    always_comb begin
        ypos_d    = ypos_q;
        vel_d     = vel_q;
        act_d     = act_q;
        ox_d      = ox_q;
        gap_d     = gap_q;
        ret_cnt_s = '0;
        sum_s     = '0;
        score_d   = score_q;
        if (move_s) begin
            if (ypos_t_s >= GY) begin
                ypos_d = GY;
                vel_d  = 11'sd0;
            end else begin
                ypos_d = ypos_t_s;
                vel_d  = vel_t_s + GR;
            end
            for (int i = 0; i < NUM_OBST; i++) begin
                if (act_q[i]) begin
                    if (ox_q[i] < SPD) begin
                        act_d[i]  = 1'b0;
                        ret_cnt_s = ret_cnt_s + CNT_W'(1);
                    end else begin
                        ox_d[i] = ox_q[i] - SPD;
                    end
                end else if (free_s[i] && spawn_want_s) begin
                    act_d[i] = 1'b1;
                    ox_d[i]  = SPX;
                end else begin
                    act_d[i] = act_q[i];
                end
            end
            if (free_s == '0) begin
                gap_d = gap_q;
            end else if (spawn_want_s) begin
                gap_d = '0;
            end else begin
                gap_d = gap_inc_s;
            end
            sum_s   = SUM_W'(score_q) + SUM_W'(ret_cnt_s);
            score_d = (sum_s > S_CAP) ? {SCORE_W{1'b1}} : sum_s[SCORE_W-1:0];
        end else begin
            score_d = score_q;
        end
    end

    // Pixel colour selection ahead of the output register.
    always_comb begin
        if (!bright) begin
            rgb_d = 12'h000;
        end else if (dino_px_s) begin
            rgb_d = (st_q == S_DONE) ? 12'hF00 : 12'h0F0;
        end else if (obst_px_s && (st_q == S_GAME || st_q == S_DONE)) begin
            rgb_d = 12'hF00;
        end else if (vCount == GROW) begin
            rgb_d = 12'h888;
        end else begin
            rgb_d = 12'hFFF;
        end
    end

    // Game FSM and all state registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            st_q      <= S_INI;
            up_q      <= 1'b0;
            lfsr_q    <= LFSR_SEED;
            ypos_q    <= GY;
            vel_q     <= 11'sd0;
            act_q     <= '0;
            for (int i = 0; i < NUM_OBST; i++) ox_q[i] <= 10'd0;
            gap_q     <= '0;
            score_q   <= '0;
            hi_q      <= '0;
            collide_q <= 1'b0;
            rgb_q     <= 12'h000;
        end else begin
            up_q      <= up;
            lfsr_q    <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            collide_q <= (st_q == S_GAME) && coll_s;
            rgb_q     <= rgb_d;
            case (st_q)
                S_INI: begin
                    if (up_rise_s) begin
                        st_q    <= S_GAME;
                        score_q <= '0;
                        act_q   <= '0;
                        gap_q   <= '0;
                        ypos_q  <= GY;
                        vel_q   <= 11'sd0;
                    end else begin
                        st_q <= S_INI;
                    end
                end
                S_GAME: begin
                    ypos_q  <= ypos_d;
                    vel_q   <= vel_d;
                    act_q   <= act_d;
                    ox_q    <= ox_d;
                    gap_q   <= gap_d;
                    score_q <= score_d;
                    if (collide_q) begin
                        st_q <= S_DONE;
                        hi_q <= (score_q > hi_q) ? score_q : hi_q;
                    end else begin
                        st_q <= S_GAME;
                    end
                end
                S_DONE: begin
                    st_q <= up_rise_s ? S_INI : S_DONE;
                end
                default: begin
                    st_q <= S_INI;
                end
            endcase
        end
    end

    assign rgb      = rgb_q;
    assign score    = score_q;
    assign hi_score = hi_q;
    assign state    = st_q;
    assign collide  = collide_q;
endmodule

// File: tb/tb_dino_game_core.sv
// Directed bench for dino_game_core: default instance plus SCORE_W=4 and single-slot variants.
module tb_dino_game_core;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        bright = 1'b0;
    logic [9:0]  hc = 10'd0;
    logic [9:0]  vc = 10'd0;
    logic        up0 = 1'b0, tick0 = 1'b0;
    logic        up4 = 1'b0, tick4 = 1'b0;
    logic        up5 = 1'b0, tick5 = 1'b0;
    logic [11:0] rgb0, rgb4, rgb5;
    logic [15:0] sc0, hi0, sc5, hi5;
    logic [3:0]  sc4, hi4;
    logic [1:0]  st0, st4, st5;
    logic        co0, co4, co5;

    int          checks = 0;
    int          errors = 0;
    logic [11:0] rgb_exp_q [$];
    int          ret_q [$];
    int          ytab [25] = '{503, 492, 482, 473, 465, 458, 452, 447, 443, 440, 438, 437, 437,
                               438, 440, 443, 447, 452, 458, 465, 473, 482, 492, 503, 515};
    int          n, tcount, retired, exp4, spawns5;
    logic        found, j, a_b;
    logic [9:0]  x_b;
    logic [31:0] g_b;

    always #5 clk = ~clk;

    dino_game_core dut (
        .clk(clk), .rst(rst), .tick(tick0), .up(up0), .bright(bright), .hCount(hc), .vCount(vc),
        .rgb(rgb0), .score(sc0), .hi_score(hi0), .state(st0), .collide(co0));

    dino_game_core #(.SCORE_W(4)) dut4 (
        .clk(clk), .rst(rst), .tick(tick4), .up(up4), .bright(bright), .hCount(hc), .vCount(vc),
        .rgb(rgb4), .score(sc4), .hi_score(hi4), .state(st4), .collide(co4));

    dino_game_core #(.NUM_OBST(1), .MIN_GAP(1)) dut5 (
        .clk(clk), .rst(rst), .tick(tick5), .up(up5), .bright(bright), .hCount(hc), .vCount(vc),
        .rgb(rgb5), .score(sc5), .hi_score(hi5), .state(st5), .collide(co5));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // one tick clock (with chosen up level) then one idle clock; returns on a negedge
    task automatic step(input int which, input logic u);
        @(negedge clk);
        case (which)
            0:       begin tick0 = 1'b1; up0 = u; end
            4:       begin tick4 = 1'b1; up4 = u; end
            default: begin tick5 = 1'b1; up5 = u; end
        endcase
        @(negedge clk);
        tick0 = 1'b0; tick4 = 1'b0; tick5 = 1'b0;
        up0 = 1'b0; up4 = 1'b0; up5 = 1'b0;
        @(negedge clk);
    endtask

    task automatic pix(input logic b, input int h, input int v, input logic [11:0] exp);
        @(negedge clk);
        bright = b; hc = 10'(h); vc = 10'(v);
        rgb_exp_q.push_back(exp);
        @(negedge clk);
        chk("rgb", rgb0, rgb_exp_q.pop_front());
    endtask

    initial begin
        // reset and idle INI
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_state", st0, 0); chk("rst_score", sc0, 0); chk("rst_hi", hi0, 0);
        chk("rst_rgb", rgb0, 0); chk("rst_collide", co0, 0);
        repeat (1000) @(negedge clk);
        chk("idle_state", st0, 0);

        // rendering in INI
        pix(1'b1, 210, 500, 12'h0F0);
        pix(1'b0, 210, 500, 12'h000);
        pix(1'b1, 0, 515, 12'h888);
        pix(1'b1, 0, 0, 12'hFFF);
        pix(1'b1, 249, 514, 12'h0F0);
        pix(1'b1, 250, 514, 12'hFFF);
        pix(1'b1, 200, 464, 12'hFFF);

        // start with up held, then jump arc (up pressed mid-air is ignored)
        @(negedge clk); up0 = 1'b1;
        repeat (5) @(negedge clk);
        chk("game_entry", st0, 1);
        up0 = 1'b0;
        repeat (3) @(negedge clk);
        chk("game_hold", st0, 1);
        for (int k = 0; k < 25; k++) begin
            step(0, (k == 0) || (k == 6));
            chk("ypos", dut.ypos_q, ytab[k]);
        end
        chk("vel_landed", dut.vel_q, 0);

        // run into the first obstacle
        n = 25; found = 1'b0;
        while (!found && n < 200) begin
            step(0, 1'b0); n++;
            found = (dut.act_q != 4'b0000);
        end
        chk("spawn_by_120", found && (n <= 120), 1);
        n = 0;
        while (!co0 && n < 300) begin
            step(0, 1'b0); n++;
        end
        chk("collide_ticks", n, 133);
        chk("state_at_collide", st0, 1);
        @(negedge clk);
        chk("done_state", st0, 2);
        chk("done_hi", hi0, 0);
        pix(1'b1, 210, 500, 12'hF00);
        pix(1'b1, 258, 480, 12'hF00);
        pix(1'b1, 100, 515, 12'h888);
        @(negedge clk); up0 = 1'b1;
        @(negedge clk); up0 = 1'b0;
        chk("done_to_ini", st0, 0);

        // 4-bit score saturation over 17 jumped obstacles
        @(negedge clk); up4 = 1'b1;
        @(negedge clk); up4 = 1'b0;
        chk("t4_entry", st4, 1);
        tcount = 0; retired = 0;
        while (retired < 17 && tcount < 3000) begin
            j = 1'b0;
            for (int i = 0; i < 4; i++) if (dut4.act_q[i] && dut4.ox_q[i] == 10'd264) j = 1'b1;
            tcount++;
            if (j) ret_q.push_back(tcount + 66);
            step(4, j);
            while (ret_q.size() > 0 && ret_q[0] == tcount) begin
                void'(ret_q.pop_front());
                retired++;
            end
            exp4 = (retired > 15) ? 15 : retired;
            chk("t4_score", sc4, exp4);
        end
        chk("t4_retired", retired, 17);
        chk("t4_state", st4, 1);
        n = 0;
        while (!co4 && n < 400) begin
            step(4, 1'b0); n++;
        end
        chk("t4_collide", co4, 1);
        @(negedge clk);
        chk("t4_done", st4, 2);
        chk("t4_hi", hi4, 15);

        // single slot, MIN_GAP=1: gap holds while the slot is busy
        @(negedge clk); up5 = 1'b1;
        @(negedge clk); up5 = 1'b0;
        spawns5 = 0;
        for (int t = 0; t < 600; t++) begin
            a_b = dut5.act_q[0]; x_b = dut5.ox_q[0]; g_b = 32'(dut5.gap_q);
            step(5, a_b && (x_b == 10'd264));
            if (a_b) begin
                chk("t5_gap_held", 32'(dut5.gap_q), g_b);
                if (x_b < 10'd4) chk("t5_retire", dut5.act_q[0], 0);
                else chk("t5_move", {dut5.act_q[0], dut5.ox_q[0]}, {1'b1, x_b - 10'd4});
            end else if (dut5.act_q[0]) begin
                spawns5++;
                chk("t5_spawn_x", dut5.ox_q[0], 780);
            end
        end
        chk("t5_spawns", spawns5 >= 2, 1);
        chk("t5_state", st5, 1);

        // reset in the middle of a game
        @(negedge clk); up0 = 1'b1;
        @(negedge clk); up0 = 1'b0;
        chk("regame", st0, 1);
        step(0, 1'b1);
        step(0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("mid_rst_state", st0, 0);
        chk("mid_rst_ypos", dut.ypos_q, 515);
        chk("mid_rst_hi4", hi4, 0);
        chk("mid_rst_score5", sc5, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
